// File: rtl/ring_addr_pkg.sv
// Shared types and one-hot ring helpers for the ring address generator.
// The helpers work on a zero-extended ring so that any DEPTH up to RING_MAX can use them.
package ring_addr_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int unsigned RING_MAX = 64;
   localparam int unsigned ADDR_MAX = 8;

   function automatic logic onehot_check(input logic [RING_MAX-1:0] ring);
      int unsigned hot;
      hot = 32'd0;
      for (int i = 0; i < RING_MAX; i++) begin
         hot = hot + {31'd0, ring[i]};
      end
      return (hot == 32'd1);
   endfunction

   // Position 0 lives in bit depth-1; position k lives in bit k-1.
   function automatic logic [ADDR_MAX-1:0] onehot_to_addr(input logic [RING_MAX-1:0] ring,
                                                          input int unsigned       depth,
                                                          input int unsigned       aw);
      logic [ADDR_MAX-1:0] pos;
      pos = ADDR_MAX'((32'd1 << aw) - 32'd1);
      if (onehot_check(ring)) begin
         pos = {ADDR_MAX{1'b0}};
         for (int i = 0; i < RING_MAX; i++) begin
            if (ring[i]) begin
               pos = (unsigned'(i) == depth - 32'd1) ? {ADDR_MAX{1'b0}} : ADDR_MAX'(i + 32'sd1);
            end else begin
               pos = pos;
            end
         end
      end else begin
         pos = pos;
      end
      return pos;
   endfunction

endpackage

// File: rtl/ring_onehot_encoder.sv
// Combinational one-hot ring to binary position encoder; any non one-hot
// pattern yields the all-ones invalid code.
module ring_onehot_encoder
   import ring_addr_pkg::*;
#(
   parameter int unsigned DEPTH = 15,
   parameter int unsigned AW    = 4
) (
   input  logic [DEPTH-1:0] ring,
   output logic [AW-1:0]    addr
);

   logic [RING_MAX-1:0] ring_ext;
   logic [ADDR_MAX-1:0] addr_wide;

   always_comb begin
      ring_ext             = {RING_MAX{1'b0}};
      ring_ext[DEPTH-1:0]  = ring;
      addr_wide            = onehot_to_addr(ring_ext, DEPTH, AW);
      addr                 = AW'(addr_wide);
   end

endmodule

// File: rtl/ring_addr_gen.sv
// Ring-counter address generator: one-hot ring stepped on request, with
// registered binary address, valid/last/done qualifiers and a sticky ring-corruption flag.
module ring_addr_gen
   import ring_addr_pkg::*;
#(
   parameter int unsigned DEPTH      = 15,
   parameter int unsigned AW         = 4,
   parameter bit          CONTINUOUS = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          step,
   output logic [AW-1:0] addr,
   output logic          addr_valid,
   output logic          last,
   output logic          done,
   output logic          err
);

   localparam logic [DEPTH-1:0] RING_INIT = {1'b1, {(DEPTH-1){1'b0}}};
   localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 32'd1);

   state_e              state_q, state_d;
   logic [DEPTH-1:0]    ring_q, ring_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic                addr_valid_q, addr_valid_d;
   logic                last_q, last_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [RING_MAX-1:0] ring_q_ext;

   // Encoding the next ring keeps addr aligned with the ring register.
   ring_onehot_encoder #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_enc (
      .ring (ring_d),
      .addr (addr_d)
   );

   always_comb begin
      state_d = state_q;
      ring_d  = ring_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               ring_d  = RING_INIT;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (start) begin
               ring_d = RING_INIT;
            end else if (step) begin
               ring_d = {ring_q[DEPTH-2:0], ring_q[DEPTH-1]};
               // addr_q is all-ones for a corrupt ring, so it never matches here.
               if (addr_q == LAST_ADDR) begin
                  done_d  = 1'b1;
                  state_d = CONTINUOUS ? RUN : IDLE;
               end else begin
                  state_d = RUN;
               end
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            ring_d  = RING_INIT;
         end
      endcase
      addr_valid_d = (state_d == RUN);
      last_d       = (state_d == RUN) && (addr_d == LAST_ADDR);
   end

   always_comb begin
      ring_q_ext            = {RING_MAX{1'b0}};
      ring_q_ext[DEPTH-1:0] = ring_q;
      if (start) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q | ~onehot_check(ring_q_ext);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         ring_q       <= RING_INIT;
         addr_q       <= {AW{1'b0}};
         addr_valid_q <= 1'b0;
         last_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ring_q       <= ring_d;
         addr_q       <= addr_d;
         addr_valid_q <= addr_valid_d;
         last_q       <= last_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign addr       = addr_q;
   assign addr_valid = addr_valid_q;
   assign last       = last_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_ring_addr_gen.sv
// Directed self-checking bench for ring_addr_gen: single-pass, continuous,
// restart, async reset, ring corruption and a small DEPTH=6/AW=3 instance.
module tb_ring_addr_gen;

   logic       clk;
   logic       rst;
   logic       start0, step0, start1, step1, start2, step2;
   logic [3:0] addr0, addr1;
   logic [2:0] addr2;
   logic       valid0, last0, done0, err0;
   logic       valid1, last1, done1, err1;
   logic       valid2, last2, done2, err2;

   int checks;
   int errors;
   int ndone;

   ring_addr_gen #(.DEPTH(15), .AW(4), .CONTINUOUS(1'b0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .step(step0), .addr(addr0),
      .addr_valid(valid0), .last(last0), .done(done0), .err(err0));

   ring_addr_gen #(.DEPTH(15), .AW(4), .CONTINUOUS(1'b1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .step(step1), .addr(addr1),
      .addr_valid(valid1), .last(last1), .done(done1), .err(err1));

   ring_addr_gen #(.DEPTH(6), .AW(3), .CONTINUOUS(1'b0)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .step(step2), .addr(addr2),
      .addr_valid(valid2), .last(last2), .done(done2), .err(err2));

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ndone  = 0;
      clk    = 1'b0;
      rst    = 1'b1;
      start0 = 1'b0; step0 = 1'b0;
      start1 = 1'b0; step1 = 1'b0;
      start2 = 1'b0; step2 = 1'b0;

      repeat (2) cyc();
      check("rst_addr",  int'(addr0),  0);
      check("rst_valid", int'(valid0), 0);
      check("rst_last",  int'(last0),  0);
      check("rst_done",  int'(done0),  0);
      check("rst_err",   int'(err0),   0);
      rst = 1'b0;
      cyc();

      // single pass, step held
      start0 = 1'b1;
      cyc();
      start0 = 1'b0;
      step0  = 1'b1;
      check("sp_addr0",  int'(addr0),  0);
      check("sp_valid0", int'(valid0), 1);
      check("sp_last0",  int'(last0),  0);
      for (int k = 1; k <= 14; k++) begin
         cyc();
         check("sp_addr",  int'(addr0),  k);
         check("sp_last",  int'(last0),  int'(k == 14));
         check("sp_done",  int'(done0),  0);
         check("sp_valid", int'(valid0), 1);
      end
      cyc();
      check("sp_end_done",  int'(done0),  1);
      check("sp_end_valid", int'(valid0), 0);
      check("sp_end_addr",  int'(addr0),  0);
      check("sp_end_last",  int'(last0),  0);
      cyc();
      check("idle_done",  int'(done0),  0);
      check("idle_addr",  int'(addr0),  0);
      check("idle_valid", int'(valid0), 0);
      step0 = 1'b0;

      // start and step together at addr 7
      start0 = 1'b1;
      cyc();
      start0 = 1'b0;
      step0  = 1'b1;
      repeat (7) cyc();
      check("rs_addr7", int'(addr0), 7);
      start0 = 1'b1;
      cyc();
      start0 = 1'b0;
      check("rs_addr",  int'(addr0),  0);
      check("rs_done",  int'(done0),  0);
      check("rs_valid", int'(valid0), 1);
      cyc();
      check("rs_next", int'(addr0), 1);

      // async reset at addr 9 with step high
      repeat (8) cyc();
      check("ar_addr9", int'(addr0), 9);
      #2 rst = 1'b1;
      #1;
      check("ar_addr",  int'(addr0),  0);
      check("ar_valid", int'(valid0), 0);
      check("ar_done",  int'(done0),  0);
      check("ar_last",  int'(last0),  0);
      #2 rst = 1'b0;
      cyc();
      check("ar_post_addr",  int'(addr0),  0);
      check("ar_post_valid", int'(valid0), 0);
      step0 = 1'b0;

      // corrupt ring at addr 5
      start0 = 1'b1;
      cyc();
      start0 = 1'b0;
      step0  = 1'b1;
      repeat (5) cyc();
      check("cr_addr5", int'(addr0), 5);
      force dut0.ring_q = 15'd0;
      cyc();
      check("cr_addr",  int'(addr0),  15);
      check("cr_err",   int'(err0),   1);
      check("cr_valid", int'(valid0), 1);
      for (int k = 0; k < 2; k++) begin
         cyc();
         check("cr_hold_addr", int'(addr0), 15);
         check("cr_hold_err",  int'(err0),  1);
         check("cr_no_done",   int'(done0), 0);
      end
      release dut0.ring_q;
      start0 = 1'b1;
      step0  = 1'b0;
      cyc();
      start0 = 1'b0;
      check("cr_fix_addr",  int'(addr0),  0);
      check("cr_fix_err",   int'(err0),   0);
      check("cr_fix_valid", int'(valid0), 1);
      step0 = 1'b1;
      cyc();
      check("cr_fix_step", int'(addr0), 1);
      check("cr_fix_err2", int'(err0),  0);
      step0 = 1'b0;

      // continuous, 40 steps
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      step1  = 1'b1;
      check("ct_addr0", int'(addr1), 0);
      for (int n = 1; n <= 40; n++) begin
         cyc();
         check("ct_addr",  int'(addr1),  n % 15);
         check("ct_done",  int'(done1),  int'((n % 15) == 0));
         check("ct_last",  int'(last1),  int'((n % 15) == 14));
         check("ct_valid", int'(valid1), 1);
         if (done1) ndone = ndone + 1;
      end
      step1 = 1'b0;
      check("ct_ndone", ndone, 2);
      check("ct_err",   int'(err1), 0);

      // DEPTH=6, AW=3 single pass
      start2 = 1'b1;
      cyc();
      start2 = 1'b0;
      step2  = 1'b1;
      check("d6_addr0", int'(addr2), 0);
      for (int n = 1; n <= 5; n++) begin
         cyc();
         check("d6_addr", int'(addr2), n);
         check("d6_last", int'(last2), int'(n == 5));
         check("d6_done", int'(done2), 0);
      end
      cyc();
      check("d6_end_addr",  int'(addr2),  0);
      check("d6_end_done",  int'(done2),  1);
      check("d6_end_valid", int'(valid2), 0);
      check("d6_err",       int'(err2),   0);
      step2 = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ring_addr_gen.md
# ring_addr_gen

Parametrised ring-counter address generator for the CNN single-layer datapath.
- Holds a DEPTH-bit one-hot ring and steps it on request.
- Outputs the position as a registered binary address for the feature-map and weight buffers, plus valid, last and done qualifiers.
- Supports single-pass and continuous (wrapping) sweeps.
- Detects a corrupted (non-one-hot) ring and flags it.

## Interface
Parameters:
- DEPTH, 15: number of ring positions (addresses 0..DEPTH-1); legal range 2..2**AW-1.
- AW, 4: address width; the all-ones code is reserved as the invalid address.
- CONTINUOUS, 0: 0 = single pass then idle; 1 = wrap from DEPTH-1 to 0 and keep running.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  pulse; loads position 0 and enters RUN.
- step  in  1  advance one position when in RUN; ignored in IDLE.
- addr  out  AW  current address; all-ones when the ring is invalid.
- addr_valid  out  1  high while in RUN.
- last  out  1  high while in RUN and addr == DEPTH-1.
- done  out  1  one-cycle pulse on the step that leaves position DEPTH-1.
- err  out  1  sticky; set when the ring is not one-hot. Cleared by rst or start.

## Operation
- Ring encoding:
  - Position 0 is bit DEPTH-1 hot.
  - Position k (k = 1..DEPTH-1) is bit k-1 hot.
  - A step rotates left: bit i moves to i+1, and bit DEPTH-1 moves to bit 0.
  - Address sequence is therefore 0,1,…,DEPTH-1.
- Encoder: exactly one bit hot gives the position number. Any other pattern (zero or multiple hot bits) gives all-ones.
- FSM states: IDLE, RUN.
  - IDLE + start → RUN; ring loaded to bit DEPTH-1 hot; err cleared.
  - RUN + start → RUN; ring reloaded (restart); done not asserted.
  - RUN + step at position < DEPTH-1 → advance.
  - RUN + step at DEPTH-1 with CONTINUOUS=1 → ring wraps to position 0; done pulses; stay in RUN.
  - RUN + step at DEPTH-1 with CONTINUOUS=0 → ring wraps to position 0; done pulses; go to IDLE.
  - RUN with no step → hold.
- start and step in the same cycle: start wins; the step is discarded.
- err:
  - Set on the cycle after the registered ring fails the one-hot check.
  - Holds until rst or start.
  - The ring is not self-corrected; only start or rst restores it.
- In IDLE the ring holds its last value (position 0 after a completed pass). addr still shows that position; addr_valid=0.

## Timing
- Reset values:
  - state = IDLE; ring = bit DEPTH-1 hot.
  - addr = 0; addr_valid = 0; last = 0; done = 0; err = 0.
- All outputs are registered.
- addr, addr_valid, last and done update on the same edge as the ring and FSM. Their next values come from next-state logic, so there is zero added latency relative to the ring.
- start sampled at edge N: addr = 0 and addr_valid = 1 from edge N.
- step sampled at edge N: addr = old + 1 from edge N.
- Final step at edge N: done = 1 for that cycle only. In single-pass mode addr_valid = 0 from edge N.
- Throughput: one address per cycle with step held high.
- Reset asserted mid-run: all outputs go to their reset values immediately (asynchronous), with no done pulse. The first edge after release sees IDLE.

## Structure
- Package ring_addr_pkg:
  - State enum (IDLE, RUN).
  - Function onehot_to_addr(ring) implementing the position mapping and the all-ones invalid code.
  - Function onehot_check(ring).
- One sub-module, ring_onehot_encoder: combinational, parametrised by DEPTH and AW. It is the generalised position encoder and is reused by the buffer read side.
- Top level contains the ring register, FSM, qualifier registers and err flag.

## Test plan
- Default params. Reset, then start, then step held for 15 cycles:
  - addr = 0,1,…,14.
  - last high only at 14.
  - done on the 15th step.
  - addr_valid = 0 after it.
- CONTINUOUS=1, DEPTH=15, 40 consecutive steps: addr wraps 14→0 twice, done pulses exactly twice, addr_valid stays 1.
- start and step in the same cycle at addr = 7: addr = 0 next cycle, no done, no advance.
- Reset asserted at addr = 9 with step high: outputs go to addr = 0, valid = 0, done = 0 before the next edge. After release, step alone does nothing.
- Force the ring to 0 at addr = 5:
  - addr = 15; err = 1 and held through steps.
  - start restores addr = 0 and err = 0.
- DEPTH=6, AW=3, single pass: addr 0..5, done after the 6th step, code 7 never seen.
